uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- Buffered 8N1 UART transmitter that drives the SoC TXD pin, which the SoC currently ties to 0.
- It is the transmit counterpart to the RXD input.
- The processor side pushes bytes into a small FIFO through a valid/ready handshake.
- A baud-timed FSM serialises the bytes LSB-first onto a registered, glitch-free line output.

Parameters:
CLOCK_FREQ, 12000000, system clock frequency in Hz
BAUD_RATE, 115200, line bit rate; CLKS_PER_BIT = CLOCK_FREQ/BAUD_RATE (integer division, must be >= 2)
FIFO_DEPTH, 4, transmit FIFO entries; power of two, >= 2

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
tx_data  input  8  byte to send
tx_valid  input  1  tx_data valid this cycle
tx_ready  output  1  FIFO can accept; equals !full
txd  output  1  serial line, idle high
busy  output  1  FIFO non-empty or FSM not IDLE
fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset values, applied asynchronously while reset=0: txd=1, tx_ready=1, busy=0, fifo_level=0, FSM=IDLE, baud counter=0, bit index=0.
- Reset mid-frame aborts the frame: txd returns to 1 immediately and the FIFO is flushed.
- Handshake:
  - A byte is accepted on a rising edge where tx_valid && tx_ready.
  - tx_data is ignored otherwise.
  - When full, tx_ready=0 and a push is dropped; the bench treats this as a protocol violation.
- FIFO:
  - Circular buffer with read/write pointers wrapping at FIFO_DEPTH.
  - Push and pop on the same edge leaves fifo_level unchanged.
  - The pop decision uses registered occupancy, so a byte pushed at edge N is poppable no earlier than edge N+1.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: txd=1. If fifo_level != 0: pop the head into the shift register, go to START, txd<=0.
  - START: hold 0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0; txd<=shift[0].
  - DATA: each bit is held CLKS_PER_BIT cycles. Shift right and increment the index. After bit 7 completes, go to STOP; txd<=1.
  - STOP: hold 1 for CLKS_PER_BIT cycles. At the end, if the FIFO is non-empty, pop and enter START directly (no idle gap); otherwise go to IDLE.
- Latency: for a byte accepted at edge N into an empty FIFO with the FSM in IDLE, txd falls at edge N+1.
- Frame length: 10*CLKS_PER_BIT cycles, from the start-bit falling edge to the end of the stop bit.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and reloads to 0 on every bit boundary.
  - Width is $clog2(CLKS_PER_BIT).
- Output timing:
  - txd is driven only from a flop.
  - busy is combinational from registered state.
  - busy deasserts on the edge that enters IDLE with an empty FIFO.

Optional Feature:
- Macro UART_TX_PARITY_EN.
- Defined:
  - An extra PARITY state sits between DATA and STOP.
  - It transmits the even-parity bit (XOR of the 8 data bits, captured at pop) for CLKS_PER_BIT cycles.
  - Frame becomes 11*CLKS_PER_BIT cycles (8E1).
- Undefined: no PARITY state, 8N1 framing exactly as above.

Test Plan:
1. Reset and idle. Hold reset=0 for 5 cycles, then release with tx_valid=0 for 100 cycles -> txd=1, busy=0, tx_ready=1, fifo_level=0 throughout.
2. Single byte. CLOCK_FREQ=1000000, BAUD_RATE=100000 (CLKS_PER_BIT=10); push 0x55 at edge N -> txd falls at N+1. Line shows 0,1,0,1,0,1,0,1,0,1, each level held exactly 10 cycles. busy drops at N+101.
3. Back-to-back. Push 0xA5, 0x3C, 0xFF on consecutive cycles -> three contiguous frames, 300 cycles total, no idle gap. LSB-first bits decoded by the bench monitor match.
4. Full FIFO. FIFO_DEPTH=4; push 6 bytes with tx_valid held high.
   - tx_ready goes low once fifo_level=4 (the first byte has already been popped).
   - Later pushes stall until a pop.
   - All 6 bytes appear on txd in order.
   - A forced push while full is dropped and not transmitted.
5. Reset mid-frame. Assert reset=0 during DATA bit 3 of 0x00 -> txd=1 within the same cycle, FIFO emptied. After release, no residual frame is sent.
6. Parity, with UART_TX_PARITY_EN defined. Send 0x07 -> parity bit=1. Send 0x03 -> parity bit=0. Each frame is 110 cycles.

Source files
------------

// File: rtl/uart_tx_if.sv
// Byte-push handshake between the processor side and the UART transmitter FIFO.
interface uart_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx.sv
// Buffered UART transmitter: small FIFO feeding a baud-timed 8N1 serialiser.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 framing).
module uart_tx #(
  parameter int CLOCK_FREQ = 12000000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  uart_tx_if.slave                     bus,
  output logic                         txd,
  output logic                         busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

  localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int PTR_W        = $clog2(FIFO_DEPTH);
  localparam int LVL_W        = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, PARITY} state_t;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [LVL_W-1:0] level_reg, level_next;
  logic             push, pop;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       idx_reg, idx_next;
  logic [7:0]       shift_reg, shift_next;
  logic             txd_reg, txd_next;
  logic             bit_end;
  logic [7:0]       head;
`ifdef UART_TX_PARITY_EN
  logic             par_reg, par_next;
`endif

  assign bus.tx_ready = (level_reg != LVL_FULL);
  assign push         = bus.tx_valid && bus.tx_ready;
  assign level_next   = level_reg + LVL_W'(push) - LVL_W'(pop);
  assign head         = mem[rd_ptr_reg];
  assign bit_end      = (cnt_reg == CNT_LAST);
  assign busy         = (state_reg != IDLE) || (level_reg != '0);
  assign fifo_level   = level_reg;
  assign txd          = txd_reg;

  // Storage is not reset; flushing is done by clearing pointers and level.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= bus.tx_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      level_reg <= level_next;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      shift_reg <= '0;
      txd_reg   <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      shift_reg <= shift_next;
      txd_reg   <= txd_next;
`ifdef UART_TX_PARITY_EN
      par_reg   <= par_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    shift_next = shift_reg;
    txd_next   = txd_reg;
    pop        = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_next   = par_reg;
`endif
    if (state_reg != IDLE) begin
      cnt_next = bit_end ? '0 : cnt_reg + CNT_W'(1);
    end
    case (state_reg)
      IDLE: begin
        txd_next = 1'b1;
        cnt_next = '0;
        if (level_reg != '0) begin
          pop        = 1'b1;
          shift_next = head;
`ifdef UART_TX_PARITY_EN
          par_next   = ^head;
`endif
          state_next = START;
          txd_next   = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_next = DATA;
          idx_next   = 3'd0;
          txd_next   = shift_reg[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_next = PARITY;
            txd_next   = par_reg;
`else
            state_next = STOP;
            txd_next   = 1'b1;
`endif
          end else begin
            shift_next = shift_reg >> 1;
            txd_next   = shift_reg[1];
            idx_next   = idx_reg + 3'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_next = STOP;
          txd_next   = 1'b1;
        end
      end
`endif
      STOP: begin
        // Chain straight into the next start bit when more data is queued.
        if (bit_end) begin
          if (level_reg != '0) begin
            pop        = 1'b1;
            shift_next = head;
`ifdef UART_TX_PARITY_EN
            par_next   = ^head;
`endif
            state_next = START;
            txd_next   = 1'b0;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        state_next = IDLE;
        txd_next   = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: table-driven single frames plus multi-cycle corner sequences.
module tb_uart_tx;
  localparam int C = 10;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FL = FRAME_BITS * C;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       txd, busy;
  logic [2:0] fifo_level;

  uart_tx_if bus();

  uart_tx #(.CLOCK_FREQ(1000000), .BAUD_RATE(100000), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .bus(bus), .txd(txd), .busy(busy), .fifo_level(fifo_level)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int falls = 0;
  logic [10:0] sb[$];
  int starts[$];

  logic        mon_active = 1'b0;
  logic        mon_prev = 1'b1;
  int          mon_k;
  logic [10:0] mon_cap;
  logic        mon_unstable;

  typedef struct {
    logic [7:0]  data;
    logic [10:0] line;   // LSB-first: start, d0..d7, parity, stop
  } vec_t;
  vec_t vecs[5];

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [10:0] fr(input logic [10:0] l);
`ifdef UART_TX_PARITY_EN
    return l;
`else
    return {2'b01, l[8:0]};
`endif
  endfunction

  function automatic logic [10:0] line_of(input logic [7:0] d);
    return {1'b1, ^d, d, 1'b0};
  endfunction

  // Line monitor: frames every bit cell, checks stability and pops the scoreboard.
  initial begin
    int bi, off;
    logic [10:0] exp;
    forever begin
      @(negedge clk);
      if (!reset) begin
        mon_active = 1'b0;
        mon_prev   = 1'b1;
      end else begin
        if (!mon_active && mon_prev && !txd) begin
          mon_active = 1'b1; mon_k = 0; mon_cap = '0; mon_unstable = 1'b0;
          starts.push_back(cyc);
          falls++;
        end
        if (mon_active) begin
          bi  = mon_k / C;
          off = mon_k % C;
          if (off == 0) mon_cap[bi] = txd;
          else if (txd !== mon_cap[bi]) mon_unstable = 1'b1;
          mon_k++;
          if (mon_k == FL) begin
            mon_active = 1'b0;
            check("bit_stable", 32'(mon_unstable), 32'd0);
            check("frame_pending", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
              exp = sb.pop_front();
              check("frame_line", 32'(mon_cap), 32'(exp));
              $display("frame line=%03h expected=%03h", mon_cap, exp);
            end
          end
        end
        mon_prev = txd;
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic [10:0] exp, output int acc);
    int n = 0;
    @(negedge clk);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    while (!bus.tx_ready && n < 3000) begin @(negedge clk); n++; end
    check("push_accept_wait", 32'(bus.tx_ready), 32'd1);
    if (bus.tx_ready) sb.push_back(exp);
    acc = cyc + 1;
    $display("push data=%02h at edge %0d", d, acc);
    @(posedge clk);
  endtask

  task automatic idle_valid();
    @(negedge clk);
    bus.tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit, output int drop);
    int n = 0;
    do begin @(negedge clk); n++; end while (busy && n < limit);
    check("idle_timeout", 32'(busy), 32'd0);
    drop = cyc;
  endtask

  initial begin
    int acc, a0, drop, n0, f0;
    logic [7:0] fbytes[6];
    vecs[0] = '{8'h55, 11'b1_0_01010101_0};
    vecs[1] = '{8'h07, 11'b1_1_00000111_0};
    vecs[2] = '{8'h03, 11'b1_0_00000011_0};
    vecs[3] = '{8'h80, 11'b1_1_10000000_0};
    vecs[4] = '{8'h00, 11'b1_0_00000000_0};
    fbytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h5A, 8'hC3};
    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b0;

    // Reset and idle
    repeat (5) @(negedge clk);
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(bus.tx_ready), 32'd1);
    check("rst_level", 32'(fifo_level), 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("idle_txd", 32'(txd), 32'd1);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_ready", 32'(bus.tx_ready), 32'd1);
      check("idle_level", 32'(fifo_level), 32'd0);
    end

    // Single frames from the vector table
    for (int i = 0; i < 5; i++) begin
      n0 = starts.size();
      send(vecs[i].data, fr(vecs[i].line), acc);
      idle_valid();
      wait_idle(FL + 50, drop);
      check("latency", (starts.size() > n0) ? 32'(starts[n0] - acc) : 32'hFFFF_FFFF, 32'd1);
      check("busy_drop", 32'(drop - acc), 32'(FL + 1));
      repeat (3) @(negedge clk);
      check("sb_drained", 32'(sb.size()), 32'd0);
    end

    // Back-to-back frames with no idle gap
    n0 = starts.size();
    send(8'hA5, fr(line_of(8'hA5)), a0);
    send(8'h3C, fr(line_of(8'h3C)), acc);
    send(8'hFF, fr(line_of(8'hFF)), acc);
    idle_valid();
    wait_idle(3 * FL + 50, drop);
    check("b2b_total", 32'(drop - a0), 32'(3 * FL + 1));
    check("b2b_frames", 32'(starts.size() - n0), 32'd3);
    if (starts.size() - n0 == 3) begin
      check("b2b_gap1", 32'(starts[n0+1] - starts[n0]), 32'(FL));
      check("b2b_gap2", 32'(starts[n0+2] - starts[n0+1]), 32'(FL));
    end
    repeat (3) @(negedge clk);

    // Full FIFO: valid held high, sixth byte stalls, forced push is dropped
    for (int k = 0; k < 5; k++) send(fbytes[k], fr(line_of(fbytes[k])), acc);
    @(negedge clk);
    check("full_ready", 32'(bus.tx_ready), 32'd0);
    check("full_level", 32'(fifo_level), 32'd4);
    send(fbytes[5], fr(line_of(fbytes[5])), acc);
    @(negedge clk);
    check("refull_ready", 32'(bus.tx_ready), 32'd0);
    bus.tx_data = 8'hEE;
    @(posedge clk);
    @(negedge clk);
    check("drop_full_level", 32'(fifo_level), 32'd4);
    bus.tx_valid = 1'b0;
    wait_idle(6 * FL + 100, drop);
    repeat (3) @(negedge clk);
    check("full_sb_empty", 32'(sb.size()), 32'd0);

    // Reset during data bit 3 of 0x00, with a second byte waiting in the FIFO
    send(8'h00, fr(line_of(8'h00)), acc);
    send(8'h00, fr(line_of(8'h00)), a0);
    idle_valid();
    repeat (4 * C + C / 2) @(negedge clk);
    check("pre_rst_level", 32'(fifo_level), 32'd1);
    check("pre_rst_txd", 32'(txd), 32'd0);
    reset = 1'b0;
    #1;
    check("midrst_txd", 32'(txd), 32'd1);
    check("midrst_level", 32'(fifo_level), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_ready", 32'(bus.tx_ready), 32'd1);
    sb.delete();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    f0 = falls;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      check("post_rst_txd", 32'(txd), 32'd1);
    end
    check("no_residual", 32'(falls - f0), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
